cobertura_motor: RTL and testbench

Motor sequencer directly downstream of the roof-cover decision logic. It consumes the open/close commands (A, F) plus both limit switches and drives the two motor contactor outputs. It guarantees the two directions are never energised together, inserts a dead-time stop before any restart or reversal, and enters a latched fault on sensor conflict or run timeout.

---
 rtl/cobertura_motor_pkg.sv | 18 +
 rtl/cobertura_motor_if.sv | 25 ++
 rtl/cobertura_motor_contador.sv | 27 ++
 rtl/cobertura_motor.sv | 113 +++++++++++
 tb/tb_cobertura_motor.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/cobertura_motor_pkg.sv
// Shared state codes and sizing helper for the roof-cover motor sequencer.
package cobertura_motor_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PARADO   = 3'd0,
        ABRINDO  = 3'd1,
        FECHANDO = 3'd2,
        PAUSA    = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    function automatic int cnt_width(input int t, input int d);
        return $clog2((t > d) ? t : d) + 1;
    endfunction

endpackage

// File: rtl/cobertura_motor_if.sv
// Command, limit-switch and contactor bundle between cover logic and motor.
interface cobertura_motor_if;
    import cobertura_motor_pkg::*;

    logic               A;
    logic               F;
    logic               Fd;
    logic               Fe;
    logic               limpa;
    logic               motor_abre;
    logic               motor_fecha;
    logic [STATE_W-1:0] estado;
    logic               falha;

    modport master (
        output A, F, Fd, Fe, limpa,
        input  motor_abre, motor_fecha, estado, falha
    );

    modport slave (
        input  A, F, Fd, Fe, limpa,
        output motor_abre, motor_fecha, estado, falha
    );

endinterface

// File: rtl/cobertura_motor_contador.sv
// Saturating up-counter with clear, enable and terminal compare.
module cobertura_motor_contador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == term);

endmodule

// File: rtl/cobertura_motor.sv
// Motor sequencer: interlocked contactors, dead-time pause, latched fault.
module cobertura_motor
    import cobertura_motor_pkg::*;
#(
    parameter int DEAD_TIME = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               reset,
    cobertura_motor_if.slave   bus
);

    localparam int CW = cnt_width(TIMEOUT, DEAD_TIME);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEAD_TIME - 1);

    estado_t       state;
    estado_t       nxt;
    logic          conflict;
    logic          clr;
    logic          en;
    logic          done;
    logic [CW-1:0] term;
    logic          abre_q;
    logic          fecha_q;
    logic          falha_q;

    assign conflict = bus.Fd & bus.Fe;
    assign term     = (state == PAUSA) ? D_LAST : T_LAST;

    // One counter serves both the run timeout and the dead time;
    // it restarts from zero on every state change.
    cobertura_motor_contador #(
        .W (CW)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .term  (term),
        .done  (done)
    );

    always_comb begin
        nxt = state;
        en  = 1'b0;
        case (state)
            PARADO: begin
                if (conflict)
                    nxt = FALHA;
                else if (bus.F && !bus.Fe)
                    nxt = FECHANDO;
                else if (bus.A && !bus.Fd)
                    nxt = ABRINDO;
            end
            ABRINDO: begin
                if (conflict)
                    nxt = FALHA;
                else if (bus.Fd || !bus.A || bus.F)
                    nxt = PAUSA;
                else if (done)
                    nxt = FALHA;
                else
                    en = 1'b1;
            end
            FECHANDO: begin
                if (conflict)
                    nxt = FALHA;
                else if (bus.Fe || !bus.F || bus.A)
                    nxt = PAUSA;
                else if (done)
                    nxt = FALHA;
                else
                    en = 1'b1;
            end
            PAUSA: begin
                if (conflict)
                    nxt = FALHA;
                else if (done)
                    nxt = PARADO;
                else
                    en = 1'b1;
            end
            FALHA: begin
                if (bus.limpa && !conflict)
                    nxt = PARADO;
            end
            default: nxt = FALHA;
        endcase
    end

    assign clr = (nxt != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PARADO;
            abre_q  <= 1'b0;
            fecha_q <= 1'b0;
            falha_q <= 1'b0;
        end else begin
            state   <= nxt;
            abre_q  <= (nxt == ABRINDO);
            fecha_q <= (nxt == FECHANDO);
            falha_q <= (nxt == FALHA);
        end
    end

    assign bus.motor_abre  = abre_q;
    assign bus.motor_fecha = fecha_q;
    assign bus.falha       = falha_q;
    assign bus.estado      = state;

endmodule

// File: tb/tb_cobertura_motor.sv
// Directed bench for cobertura_motor with TIMEOUT=20, DEAD_TIME=4.
module tb_cobertura_motor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    cobertura_motor_if bus ();

    cobertura_motor #(
        .DEAD_TIME (4),
        .TIMEOUT   (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st,
                            input logic ab, input logic fe,
                            input logic fa);
        chk({tag, "_estado"}, 32'(bus.estado), 32'(st));
        chk({tag, "_abre"}, 32'(bus.motor_abre), 32'(ab));
        chk({tag, "_fecha"}, 32'(bus.motor_fecha), 32'(fe));
        chk({tag, "_falha"}, 32'(bus.falha), 32'(fa));
    endtask

    initial begin
        bus.A = 0; bus.F = 0; bus.Fd = 0; bus.Fe = 0; bus.limpa = 0;
        #12;
        chk_outs("reset", 3'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Open to limit switch
        bus.A = 1;
        step();
        chk_outs("open_start", 3'd1, 1, 0, 0);
        repeat (8) step();
        chk("open_running", 32'(bus.motor_abre), 32'd1);
        bus.Fd = 1;
        step();
        chk_outs("open_limit", 3'd3, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pausa_hold", 32'(bus.estado), 32'd3);
        end
        step();
        chk_outs("pausa_done", 3'd0, 0, 0, 0);
        step();
        chk("parado_at_limit", 32'(bus.estado), 32'd0);
        bus.A = 0; bus.Fd = 0;

        // Reversal open -> close
        bus.A = 1;
        step();
        chk("rev_open", 32'(bus.motor_abre), 32'd1);
        repeat (3) step();
        bus.A = 0; bus.F = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rev_low", 32'(bus.motor_abre | bus.motor_fecha), 32'd0);
            step();
        end
        chk_outs("rev_close", 3'd2, 0, 1, 0);

        // Timeout: already one cycle of motor_fecha observed
        n = 0;
        while (bus.motor_fecha && n < 50) begin
            n++;
            chk("interlock", 32'(bus.motor_abre & bus.motor_fecha), 32'd0);
            step();
        end
        chk("timeout_len", 32'(n), 32'd20);
        chk_outs("timeout_fault", 3'd4, 0, 0, 1);
        bus.F = 0;
        step();
        chk("fault_latched", 32'(bus.estado), 32'd4);
        bus.limpa = 1;
        step();
        chk_outs("fault_clear", 3'd0, 0, 0, 0);
        bus.limpa = 0;

        // Sensor conflict while closing
        bus.F = 1;
        step();
        chk("conf_run", 32'(bus.estado), 32'd2);
        bus.Fd = 1; bus.Fe = 1;
        step();
        chk_outs("conf_fault", 3'd4, 0, 0, 1);
        bus.limpa = 1;
        step();
        chk("conf_hold", 32'(bus.estado), 32'd4);
        bus.Fd = 0;
        step();
        chk("conf_clear", 32'(bus.estado), 32'd0);
        bus.limpa = 0;
        step();
        chk("closed_stays", 32'(bus.estado), 32'd0);

        // Close has priority; A=F=1 while running stops
        bus.Fe = 0; bus.A = 1; bus.F = 1;
        step();
        chk_outs("prio_close", 3'd2, 0, 1, 0);
        step();
        chk_outs("both_stop", 3'd3, 0, 0, 0);
        bus.A = 0; bus.F = 0;
        repeat (4) step();
        chk("both_parado", 32'(bus.estado), 32'd0);

        // Asynchronous mid-run reset
        bus.A = 1;
        step();
        chk("mid_open", 32'(bus.motor_abre), 32'd1);
        step();
        #3;
        reset = 1'b1;
        #1;
        chk_outs("async_reset", 3'd0, 0, 0, 0);
        #2;
        reset = 1'b0;
        step();
        chk_outs("restart", 3'd1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
